// File: rtl/st_width_downconv.sv
// Avalon-ST width down-converter: splits each IN_W-bit beat into OUT_W-bit lanes,
// emitting lane 0 first and skipping trailing lanes that are wholly empty.
module st_width_downconv #(
    parameter int IN_W   = 512,
    parameter int OUT_W  = 128,
    parameter int IN_EW  = $clog2(IN_W / 8),
    parameter int OUT_EW = $clog2(OUT_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [IN_EW-1:0]  in_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [OUT_EW-1:0] out_empty
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int LW    = $clog2(RATIO);
    localparam int IN_B  = IN_W / 8;
    localparam int OUT_B = OUT_W / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state;
    logic              busy;
    logic [IN_W-1:0]   buffer;
    logic [LW-1:0]     lane;
    logic [LW-1:0]     last_lane;
    logic              sop_q;
    logic              eop_q;
    logic [OUT_EW-1:0] empty_q;

    logic              accept;
    logic              at_last;
    logic [31:0]       e_eff;
    logic [31:0]       vb;
    logic [31:0]       ll32;
    logic [31:0]       pad;
    logic [LW-1:0]     last_lane_n;
    logic [OUT_EW-1:0] empty_n;

    assign busy    = (state == DRAIN);
    assign at_last = (lane == last_lane);
    assign accept  = in_valid && in_ready;

    // Only combinational path: a finishing last lane frees the buffer in the same cycle.
    assign in_ready = !rst && (!busy || (out_ready && at_last));

    // Empty only counts on EOP beats; pad is the unused byte count inside the final lane.
    always_comb begin
        e_eff = in_endofpacket ? 32'(in_empty) : 32'd0;
        if (e_eff > 32'(IN_B - 1))
            e_eff = 32'(IN_B - 1);
        vb          = 32'(IN_B) - e_eff;
        ll32        = (vb - 32'd1) / 32'(OUT_B);
        pad         = (ll32 + 32'd1) * 32'(OUT_B) - vb;
        last_lane_n = LW'(ll32);
        empty_n     = OUT_EW'(pad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buffer    <= '0;
            lane      <= '0;
            last_lane <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            empty_q   <= '0;
        end else if (accept) begin
            state     <= DRAIN;
            buffer    <= in_data;
            lane      <= '0;
            last_lane <= last_lane_n;
            sop_q     <= in_startofpacket;
            eop_q     <= in_endofpacket;
            empty_q   <= empty_n;
        end else if (busy && out_ready) begin
            if (at_last)
                state <= IDLE;
            else
                lane <= lane + 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (lane == LW'(k))
                out_data = buffer[OUT_W*k +: OUT_W];
        end
    end

    assign out_valid         = busy;
    assign out_startofpacket = sop_q && (lane == '0);
    assign out_endofpacket   = eop_q && at_last;
    assign out_empty         = (eop_q && at_last) ? empty_q : '0;

endmodule

// File: doc/st_width_downconv.md
Name: st_width_downconv

Overview:
- Parametrised Avalon-ST width down-converter that splits each accepted IN_W-bit beat into IN_W/OUT_W narrower output beats.
- Generalises the fixed 512-to-128 adapter with:
  - configurable widths;
  - full output back-pressure;
  - zero-bubble back-to-back input acceptance;
  - SOP/EOP propagation;
  - empty-byte accounting, so trailing unused lanes are dropped.
- Sits between the wide packet datapath and narrower consumers (e.g. 128-bit matchers or DMA).

Parameters:
IN_W, 512, input data width in bits; must be a multiple of OUT_W
OUT_W, 128, output data width in bits; must be a multiple of 8
RATIO, IN_W/OUT_W, lanes per input beat; derived, must be >= 2
IN_EW, log2(IN_W/8), width of in_empty
OUT_EW, log2(OUT_W/8), width of out_empty

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  IN_W  input data; lane k = in_data[OUT_W*k +: OUT_W], lane 0 is emitted first
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  IN_EW  unused bytes at top of beat; meaningful only with in_endofpacket
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_data  out  OUT_W  current lane
out_startofpacket  out  1  first output beat of packet
out_endofpacket  out  1  last output beat of packet
out_empty  out  OUT_EW  unused top bytes of the out_endofpacket beat; 0 otherwise

Behaviour:
Reset and clocking:
- Synchronous active-high reset on rising clk edge.
- While rst is high, in_ready = 0.
- Cleared on reset: out_valid, out_startofpacket, out_endofpacket, out_empty, out_data, lane counter, buffer, busy flag.

State:
- Two states, IDLE (busy=0) and DRAIN (busy=1).
- State is held in a single IN_W holding register plus:
  - lane counter `lane`, width clog2(RATIO);
  - `last_lane`;
  - latched sop, eop and empty fields.

Input acceptance:
- in_ready = !rst && (!busy || (out_valid && out_ready && lane == last_lane)).
- in_ready is combinational from out_ready; this is the only combinational path.
- On accept:
  - load the buffer;
  - set lane = 0 and busy = 1;
  - latch sop, eop and last_lane.

Lane computation:
- Effective empty: e = in_empty if in_endofpacket, else 0.
- e is saturated to IN_W/8 - 1.
- valid bytes: vb = IN_W/8 - e.
- last_lane = (vb - 1) / (OUT_W/8). Integer division; no other arithmetic required.
- Non-EOP beats always use last_lane = RATIO - 1.

Latency and output data:
- Beat accepted at edge N gives out_valid = 1 in the cycle after edge N, showing lane 0.
- out_valid = busy.
- out_data = buffer lane[lane].

Output flags:
- out_startofpacket = latched sop && lane == 0.
- out_endofpacket = latched eop && lane == last_lane.
- out_empty = (last_lane + 1) * (OUT_W/8) - vb on the out_endofpacket beat, else 0.

Output handshake:
- On out_valid && out_ready:
  - if lane < last_lane, lane increments;
  - if lane == last_lane, either a new beat is accepted in the same cycle (lane = 0, busy stays 1) or busy clears.
- While out_valid && !out_ready, out_data and all out_* fields hold stable. No drop, no duplicate.

Lane skipping:
- Lanes above last_lane are never emitted.
- Throughput is one output beat per cycle with out_ready held high, with no bubble between input beats.

Protocol errors:
- Protocol violations (missing SOP/EOP) are not checked.
- Beats are forwarded as received.

Reset mid-packet:
- The partial beat is discarded.
- out_valid = 0 the cycle after the reset edge.
- in_ready = 1 the first cycle rst is low.

Test Plan:
Defaults IN_W=512, OUT_W=128; lane k bytes = 8'hk.

1. One beat, sop=eop=1, empty=0, out_ready=1.
   -> 4 beats, lanes 0..3, on consecutive cycles starting 1 cycle after accept; sop on beat 0, eop on beat 3, out_empty=0.
2. One beat, eop=1, empty=40 (vb=24).
   -> 2 beats; eop on beat 1, out_empty=8. Lanes 2-3 never appear; in_ready is high on the cycle beat 1 is taken.
3. One beat, empty=63.
   -> 1 beat, sop=eop=1, out_empty=15. Separately, a non-EOP beat with empty=10 -> 4 beats, out_empty=0.
4. Three-beat packet presented back-to-back, out_ready=1.
   -> 12 consecutive out_valid cycles with no gap; in_ready pulses exactly on lane-3 cycles; sop only on output 0, eop only on output 11.
5. out_ready pattern 1,0,0,1,0,1...
   -> out_data and flags constant across every stall; output sequence identical to case 4; in_ready never high while lane != last_lane.
6. rst asserted for 1 cycle while lane=2 is stalled.
   -> out_valid=0 and all out_* = 0 next cycle; in_ready=1 after rst falls; the next packet emits from lane 0 with sop=1.
